// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default sizing, read-port mode and width helpers.
package fifo_pkg;

    localparam int unsigned FIFO_WIDTH_DEF     = 8;
    localparam int unsigned FIFO_ADDR_BITS_DEF = 4;
    localparam int unsigned FIFO_AEMPTY_DEF    = 2;

    typedef enum logic {
        RD_REGISTERED = 1'b0,
        RD_ASYNC      = 1'b1
    } rd_port_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) r++;
        return r;
    endfunction

    // Occupancy needs one extra bit so that "full" (DEPTH) is representable.
    function automatic int unsigned level_bits(input int unsigned addr_bits);
        return addr_bits + 1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port RAM, WIDTH x 2^ADDR_BITS, with registered or asynchronous read.
module fifo_ram import fifo_pkg::*; #(
    parameter int unsigned WIDTH     = FIFO_WIDTH_DEF,
    parameter int unsigned ADDR_BITS = FIFO_ADDR_BITS_DEF,
    parameter rd_port_e    RD_MODE   = RD_REGISTERED
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic                 re,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [WIDTH-1:0]     rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_BITS;

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    generate
        if (RD_MODE == RD_REGISTERED) begin : g_rd_reg
            // No reset on the read register so the array maps onto block RAM.
            always_ff @(posedge clk) begin
                if (re) rdata <= mem[raddr];
            end
        end else begin : g_rd_async
            logic unused_re;
            assign unused_re = re;
            assign rdata     = mem[raddr];
        end
    endgenerate

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with clock-enable, flags, sticky status and flush.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through output.
module sync_fifo_param import fifo_pkg::*; #(
    parameter int unsigned WIDTH      = FIFO_WIDTH_DEF,
    parameter int unsigned ADDR_BITS  = FIFO_ADDR_BITS_DEF,
    parameter int unsigned AFULL_LVL  = (1 << ADDR_BITS) - 2,
    parameter int unsigned AEMPTY_LVL = FIFO_AEMPTY_DEF
) (
    input  logic                              clk,
    input  logic                              resetN,
    input  logic                              clkEn,
    input  logic                              clear,
    input  logic                              wrEn,
    input  logic [WIDTH-1:0]                  din,
    input  logic                              rdEn,
    output logic [WIDTH-1:0]                  dout,
    output logic                              doutValid,
    output logic                              fifoEmpty,
    output logic                              fifoFull,
    output logic                              almostFull,
    output logic                              almostEmpty,
    output logic [level_bits(ADDR_BITS)-1:0]  level,
    output logic                              overflow,
    output logic                              underflow
);

    localparam int unsigned       LW       = level_bits(ADDR_BITS);
    localparam logic [LW-1:0]     DEPTH_L  = LW'(1 << ADDR_BITS);
    localparam logic [LW-1:0]     AFULL_L  = LW'(AFULL_LVL);
    localparam logic [LW-1:0]     AEMPTY_L = LW'(AEMPTY_LVL);

    logic [ADDR_BITS-1:0] wrAddr, rdAddr;
    logic [WIDTH-1:0]     ramQ;
    logic                 rdAcc, wrAcc, rdGo, wrGo;

    assign fifoEmpty   = (level == '0);
    assign fifoFull    = (level == DEPTH_L);
    assign almostFull  = (level >= AFULL_L);
    assign almostEmpty = (level <= AEMPTY_L);

    assign rdAcc = clkEn & rdEn & ~fifoEmpty;
    assign wrAcc = clkEn & wrEn & (~fifoFull | rdAcc);
    // Flush wins: suppress RAM write and read-register load in a clear cycle.
    assign rdGo  = rdAcc & ~clear;
    assign wrGo  = wrAcc & ~clear;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            wrAddr    <= '0;
            rdAddr    <= '0;
            level     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clkEn) begin
            if (clear) begin
                wrAddr    <= '0;
                rdAddr    <= '0;
                level     <= '0;
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end else begin
                if (wrAcc) wrAddr <= wrAddr + 1'b1;
                if (rdAcc) rdAddr <= rdAddr + 1'b1;
                if (wrAcc && !rdAcc)      level <= level + 1'b1;
                else if (rdAcc && !wrAcc) level <= level - 1'b1;
                if (wrEn && !wrAcc) overflow  <= 1'b1;
                if (rdEn && !rdAcc) underflow <= 1'b1;
            end
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    localparam rd_port_e RD_MODE = RD_ASYNC;

    assign dout      = ramQ;
    assign doutValid = ~fifoEmpty;
`else
    localparam rd_port_e RD_MODE = RD_REGISTERED;

    logic validQ, loaded;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            validQ <= 1'b0;
            loaded <= 1'b0;
        end else if (clkEn) begin
            validQ <= rdGo;
            if (rdGo) loaded <= 1'b1;
        end
    end

    // The RAM read register has no reset; mask it until the first read loads it.
    assign dout      = loaded ? ramQ : '0;
    assign doutValid = validQ;
`endif

    fifo_ram #(
        .WIDTH     (WIDTH),
        .ADDR_BITS (ADDR_BITS),
        .RD_MODE   (RD_MODE)
    ) u_ram (
        .clk   (clk),
        .we    (wrGo),
        .waddr (wrAddr),
        .wdata (din),
        .re    (rdGo),
        .raddr (rdAddr),
        .rdata (ramQ)
    );

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: queue-based data model plus flag checks.
module tb_sync_fifo_param;

    localparam int DEPTH = 16;
    localparam int AFL   = 14;
    localparam int AEL   = 2;

    logic       clk = 1'b0;
    logic       resetN, clkEn, clear, wrEn, rdEn;
    logic [7:0] din, dout;
    logic       doutValid, fifoEmpty, fifoFull, almostFull, almostEmpty;
    logic [4:0] level;
    logic       overflow, underflow;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] sb[$];
    int         m_level;
    logic       m_ovf, m_udf, m_valid;
    logic [7:0] m_dout;

    always #5 clk = ~clk;

    sync_fifo_param #(
        .WIDTH      (8),
        .ADDR_BITS  (4),
        .AFULL_LVL  (AFL),
        .AEMPTY_LVL (AEL)
    ) dut (
        .clk         (clk),
        .resetN      (resetN),
        .clkEn       (clkEn),
        .clear       (clear),
        .wrEn        (wrEn),
        .din         (din),
        .rdEn        (rdEn),
        .dout        (dout),
        .doutValid   (doutValid),
        .fifoEmpty   (fifoEmpty),
        .fifoFull    (fifoFull),
        .almostFull  (almostFull),
        .almostEmpty (almostEmpty),
        .level       (level),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_level = 0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
        m_valid = 1'b0;
        m_dout  = 8'h00;
    endtask

    task automatic check_outputs();
        check_eq("level",       32'(level),       32'(m_level));
        check_eq("fifoEmpty",   32'(fifoEmpty),   32'(m_level == 0));
        check_eq("fifoFull",    32'(fifoFull),    32'(m_level == DEPTH));
        check_eq("almostFull",  32'(almostFull),  32'(m_level >= AFL));
        check_eq("almostEmpty", 32'(almostEmpty), 32'(m_level <= AEL));
        check_eq("overflow",    32'(overflow),    32'(m_ovf));
        check_eq("underflow",   32'(underflow),   32'(m_udf));
`ifdef SYNC_FIFO_FWFT_EN
        check_eq("doutValid",   32'(doutValid),   32'(m_level != 0));
        if (m_level != 0) check_eq("dout_head", 32'(dout), 32'(sb[0]));
`else
        check_eq("doutValid",   32'(doutValid),   32'(m_valid));
        check_eq("dout",        32'(dout),        32'(m_dout));
`endif
    endtask

    // Drive one cycle of stimulus, advance the model, then check after the edge.
    task automatic step(input logic ce, input logic we, input logic re,
                        input logic cl, input logic [7:0] d);
        logic rd_ok, wr_ok;
        clkEn = ce; wrEn = we; rdEn = re; clear = cl; din = d;
        rd_ok = ce && re && (m_level != 0);
        wr_ok = ce && we && ((m_level != DEPTH) || rd_ok);
        @(posedge clk);
        #1;
        if (ce) begin
            if (cl) begin
                sb.delete();
                m_level = 0;
                m_ovf   = 1'b0;
                m_udf   = 1'b0;
                m_valid = 1'b0;
            end else begin
                if (we && !wr_ok) m_ovf = 1'b1;
                if (re && !rd_ok) m_udf = 1'b1;
                m_valid = rd_ok;
                if (rd_ok) m_dout = sb.pop_front();
                if (wr_ok) sb.push_back(d);
                m_level = sb.size();
            end
        end
        check_outputs();
    endtask

    initial begin
        resetN = 1'b0; clkEn = 1'b0; clear = 1'b0;
        wrEn = 1'b0; rdEn = 1'b0; din = 8'h00;
        model_reset();
        #12;
        check_outputs();
        check_eq("rst_empty",  32'(fifoEmpty),   32'd1);
        check_eq("rst_aempty", 32'(almostEmpty), 32'd1);
        resetN = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 8'(i));
        check_eq("full_after16",  32'(fifoFull), 32'd1);
        check_eq("level_after16", 32'(level),    32'd16);

        // Streaming from full across pointer wrap.
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 8'(8'h10 + i));
        check_eq("stream_level",  32'(level),    32'd16);
        check_eq("stream_no_ovf", 32'(overflow), 32'd0);

        step(1'b1, 1'b1, 1'b0, 1'b0, 8'hAA);
        check_eq("ovf_17th",   32'(overflow), 32'd1);
        check_eq("level_17th", 32'(level),    32'd16);

        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        check_eq("udf_empty_rd", 32'(underflow), 32'd1);
        check_eq("valid_empty_rd", 32'(doutValid), 32'd0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 8'h5A);
        check_eq("level_wr_rd_empty", 32'(level), 32'd1);
`ifndef SYNC_FIFO_FWFT_EN
        check_eq("no_read_when_empty", 32'(doutValid), 32'd0);
`endif

        // Streaming with clkEn at 1/3 duty.
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 36; i++)
            step(1'((i % 3) == 0), 1'b1, 1'(i >= 6), 1'b0, 8'(8'h80 + i));
        for (int i = 0; i < 9; i++)
            step(1'((i % 3) == 0), 1'b0, 1'b1, 1'b0, 8'h00);

        // Clear with write at level 9, sticky flags previously set.
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 8'(8'h30 + i));
        check_eq("level_before_clr", 32'(level), 32'd9);
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'hEE);
        check_eq("clr_level", 32'(level),     32'd0);
        check_eq("clr_empty", 32'(fifoEmpty), 32'd1);
        check_eq("clr_ovf",   32'(overflow),  32'd0);
        check_eq("clr_udf",   32'(underflow), 32'd0);

        // Asynchronous reset in the middle of streaming.
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 8'(8'h60 + i));
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 8'(8'h70 + i));
        #2 resetN = 1'b0;
        #1;
        model_reset();
        check_outputs();
        check_eq("rst_mid_level", 32'(level),     32'd0);
        check_eq("rst_mid_udf",   32'(underflow), 32'd0);
        clkEn = 1'b0; wrEn = 1'b0; rdEn = 1'b0;
        #1 resetN = 1'b1;
        @(posedge clk);
        #1;

        // Threshold sweep while filling.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
`ifdef SYNC_FIFO_FWFT_EN
            if (i == 0) check_eq("fwft_first", 32'(dout), 32'h40);
`endif
            if (m_level == 2)  check_eq("aempty_at2", 32'(almostEmpty), 32'd1);
            if (m_level == 3)  check_eq("aempty_at3", 32'(almostEmpty), 32'd0);
            if (m_level == 13) check_eq("afull_at13", 32'(almostFull),  32'd0);
            if (m_level == 14) check_eq("afull_at14", 32'(almostFull),  32'd1);
        end

        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
